// File: rtl/region_press_decoder.sv
// Debounces the smoothed colour-region stream into discrete press events and
// queues them in a small first-word-fall-through FIFO for the game controller.
module region_press_decoder #(
  parameter int unsigned HOLD_SAMPLES    = 3,
  parameter int unsigned RELEASE_SAMPLES = 2,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                          PCLK,
  input  logic                          reset,
  input  logic                          en,
  input  logic [3:0]                    green_region,
  output logic                          press_valid,
  output logic [1:0]                    press_color,
  input  logic                          press_ready,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StArmed, StCandidate, StWaitRelease} state_e;

  state_e     state_q, state_d;
  logic [3:0] hcnt_q, hcnt_d;
  logic [3:0] rcnt_q, rcnt_d;
  logic [1:0] cand_q, cand_d;

  logic       is_none, is_single;
  logic [1:0] single_idx;
  logic [3:0] hcnt_inc, rcnt_inc;
  logic       push;
  logic [1:0] push_color;

  logic [1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          fifo_full, pop, push_ok;

  // Classify the sample: no colour, exactly one colour (and which), or several.
  always_comb begin
    is_none    = (green_region == 4'b0000);
    is_single  = 1'b1;
    single_idx = 2'd0;
    unique case (green_region)
      4'b0001: single_idx = 2'd0;
      4'b0010: single_idx = 2'd1;
      4'b0100: single_idx = 2'd2;
      4'b1000: single_idx = 2'd3;
      default: is_single = 1'b0;
    endcase
  end

  assign hcnt_inc = hcnt_q + 4'd1;
  assign rcnt_inc = rcnt_q + 4'd1;

  // Detector state register and counters.
  always_ff @(posedge PCLK) begin
    if (reset) begin
      state_q <= StArmed;
      hcnt_q  <= 4'd0;
      rcnt_q  <= 4'd0;
      cand_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      rcnt_q  <= rcnt_d;
      cand_q  <= cand_d;
    end
  end

  // Detector next-state; only strobed samples advance it.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    rcnt_d  = rcnt_q;
    cand_d  = cand_q;
    if (en) begin
      unique case (state_q)
        StArmed: begin
          if (is_single) begin
            cand_d = single_idx;
            hcnt_d = 4'd1;
            if (HOLD_SAMPLES == 1) begin
              state_d = StWaitRelease;
              rcnt_d  = 4'd0;
            end else begin
              state_d = StCandidate;
            end
          end
        end
        StCandidate: begin
          if (is_single && (single_idx == cand_q)) begin
            hcnt_d = hcnt_inc;
            if (hcnt_inc == 4'(HOLD_SAMPLES)) begin
              state_d = StWaitRelease;
              rcnt_d  = 4'd0;
            end
          end else if (is_single) begin
            cand_d = single_idx;
            hcnt_d = 4'd1;
          end else begin
            state_d = StArmed;
            hcnt_d  = 4'd0;
          end
        end
        StWaitRelease: begin
          if (is_none) begin
            rcnt_d = rcnt_inc;
            if (rcnt_inc == 4'(RELEASE_SAMPLES)) begin
              state_d = StArmed;
              rcnt_d  = 4'd0;
              hcnt_d  = 4'd0;
            end
          end else begin
            rcnt_d = 4'd0;
          end
        end
        default: begin
          state_d = StArmed;
          hcnt_d  = 4'd0;
        end
      endcase
    end
  end

  // Press event generation: fires on the sample that completes the hold.
  always_comb begin
    push       = 1'b0;
    push_color = single_idx;
    if (en && is_single) begin
      unique case (state_q)
        StArmed:     push = (HOLD_SAMPLES == 1);
        StCandidate: push = (single_idx == cand_q) && (hcnt_inc == 4'(HOLD_SAMPLES));
        default:     push = 1'b0;
      endcase
    end
  end

  assign fifo_full = (count_q == CW'(FIFO_DEPTH));
  assign pop       = (count_q != '0) && press_ready;
  // A full queue still accepts a push when the head leaves on the same edge.
  assign push_ok   = push && (!fifo_full || pop);

  // FIFO pointers, occupancy and the registered overflow pulse.
  always_ff @(posedge PCLK) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop)     rptr_q <= rptr_q + AW'(1);
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      overflow_q <= push && fifo_full && !pop;
    end
  end

  // FIFO storage; contents are don't-care outside the valid window.
  always_ff @(posedge PCLK) begin
    if (!reset && push_ok) mem_q[wptr_q] <= push_color;
  end

  assign press_valid = (count_q != '0);
  assign press_color = press_valid ? mem_q[rptr_q] : 2'd0;
  assign overflow    = overflow_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_region_press_decoder.sv
// Directed bench for region_press_decoder with default parameters.
module tb_region_press_decoder;

  logic       PCLK = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [3:0] green_region = 4'b0000;
  logic       press_ready = 1'b0;
  logic       press_valid;
  logic [1:0] press_color;
  logic       overflow;
  logic [2:0] fifo_count;

  int n_checks = 0;
  int n_pass   = 0;

  region_press_decoder #(
    .HOLD_SAMPLES   (3),
    .RELEASE_SAMPLES(2),
    .FIFO_DEPTH     (4)
  ) dut (
    .PCLK        (PCLK),
    .reset       (reset),
    .en          (en),
    .green_region(green_region),
    .press_valid (press_valid),
    .press_color (press_color),
    .press_ready (press_ready),
    .overflow    (overflow),
    .fifo_count  (fifo_count)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // One strobed sample; outputs are observable right after return.
  task automatic sample(input logic [3:0] r);
    en = 1'b1;
    green_region = r;
    tick();
    en = 1'b0;
  endtask

  // n strobed samples, each followed by an idle cycle with the region held.
  task automatic hold(input logic [3:0] r, input int n);
    for (int i = 0; i < n; i++) begin
      sample(r);
      tick();
    end
  endtask

  task automatic release_zeros();
    hold(4'b0000, 2);
  endtask

  task automatic pop_expect(input string tag, input int color);
    check({tag, "_valid"}, press_valid, 1);
    check({tag, "_color"}, press_color, color);
    press_ready = 1'b1;
    tick();
    press_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    reset = 1'b0;
    check("rst_valid", press_valid, 0);
    check("rst_color", press_color, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", overflow, 0);

    // Basic green press
    hold(4'b0010, 2);
    check("g_before3", press_valid, 0);
    sample(4'b0010);
    check("g_valid", press_valid, 1);
    check("g_color", press_color, 1);
    check("g_count", fifo_count, 1);
    tick();
    pop_expect("g_pop", 1);
    check("g_empty", press_valid, 0);
    release_zeros();

    // MULTI restarts the hold
    hold(4'b0100, 2);
    hold(4'b1100, 1);
    hold(4'b0100, 2);
    check("y_no_early", fifo_count, 0);
    sample(4'b0100);
    check("y_count", fifo_count, 1);
    check("y_color", press_color, 2);
    tick();
    pop_expect("y_pop", 2);
    release_zeros();

    // Re-arm requires two consecutive zeros
    hold(4'b0001, 3);
    check("r1_count", fifo_count, 1);
    hold(4'b0001, 5);
    check("r_hold_count", fifo_count, 1);
    hold(4'b0000, 1);
    hold(4'b0001, 1);
    hold(4'b0000, 1);
    hold(4'b0001, 3);
    check("r_no_rearm", fifo_count, 1);
    hold(4'b0000, 2);
    hold(4'b0001, 2);
    check("r2_partial", fifo_count, 1);
    hold(4'b0001, 1);
    check("r2_count", fifo_count, 2);
    pop_expect("r_pop1", 0);
    pop_expect("r_pop2", 0);
    check("r_empty", fifo_count, 0);
    release_zeros();

    // Fill to full and overflow on the fifth press
    hold(4'b0001, 3); release_zeros();
    hold(4'b0010, 3); release_zeros();
    hold(4'b0100, 3); release_zeros();
    hold(4'b1000, 3); release_zeros();
    check("full_count", fifo_count, 4);
    check("full_no_ovf", overflow, 0);
    hold(4'b0001, 2);
    sample(4'b0001);
    check("ovf_pulse", overflow, 1);
    check("ovf_count", fifo_count, 4);
    tick();
    check("ovf_one_cycle", overflow, 0);
    check("ovf_head", press_color, 0);
    release_zeros();

    // Push and pop on the same edge while full
    hold(4'b0010, 2);
    press_ready = 1'b1;
    sample(4'b0010);
    press_ready = 1'b0;
    check("pp_no_ovf", overflow, 0);
    check("pp_count", fifo_count, 4);
    check("pp_head", press_color, 1);
    tick();
    check("pp_no_ovf2", overflow, 0);
    release_zeros();
    pop_expect("dr0", 1);
    pop_expect("dr1", 2);
    pop_expect("dr2", 3);
    pop_expect("dr3", 1);
    check("dr_valid", press_valid, 0);
    check("dr_count", fifo_count, 0);
    press_ready = 1'b1;
    tick();
    press_ready = 1'b0;
    check("empty_pop", fifo_count, 0);

    // Reset mid-candidate with queued events
    hold(4'b0100, 3); release_zeros();
    hold(4'b1000, 3); release_zeros();
    check("pre_rst_count", fifo_count, 2);
    hold(4'b0001, 2);
    reset = 1'b1;
    sample(4'b0001);
    reset = 1'b0;
    check("mrst_valid", press_valid, 0);
    check("mrst_count", fifo_count, 0);
    check("mrst_color", press_color, 0);
    tick();
    hold(4'b0001, 1);
    check("mrst_fresh1", fifo_count, 0);
    hold(4'b0001, 1);
    check("mrst_fresh2", fifo_count, 0);
    sample(4'b0001);
    check("mrst_event", fifo_count, 1);
    check("mrst_ev_color", press_color, 0);
    check("mrst_ev_valid", press_valid, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/region_press_decoder.md
# region_press_decoder

Consumes the smoothed per-window colour detection stream (`en` strobe plus `green_region[3:0]`) produced by the camera-side smoother and turns it into discrete, debounced colour-press events for the game controller. A press is one colour region held alone for a configurable number of windows; the block then re-arms only after the scene returns to "no colour" for a configurable number of windows. Events are queued in a small first-word-fall-through FIFO with a valid/ready handshake toward the game FSM.

## Interface
- `HOLD_SAMPLES`, 3: consecutive qualifying `en` samples of the same single colour needed to register a press (range 1–15).
- `RELEASE_SAMPLES`, 2: consecutive all-zero `en` samples needed to re-arm after a press (range 1–15).
- `FIFO_DEPTH`, 4: event queue depth, power of two, ≥2.

- `PCLK` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `en` in 1: one-cycle strobe; `green_region` valid when high.
- `green_region` in 4: bit0 red, bit1 green, bit2 yellow, bit3 blue.
- `press_valid` out 1: FIFO head holds an event.
- `press_color` out 2: head colour code, 0 red, 1 green, 2 yellow, 3 blue (equals bit index).
- `press_ready` in 1: consumer accepts head when `press_valid && press_ready`.
- `overflow` out 1: one-cycle pulse when a press is dropped because the FIFO is full.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: number of queued events.

## Operation
- Sample classification (only on cycles with `en`=1): NONE = 4'b0000; SINGLE(k) = exactly one bit k set; MULTI = two or more bits set. Cycles with `en`=0 change no detector state.
- Detector FSM, states ARMED, CANDIDATE, WAIT_RELEASE; hold counter `hcnt` and release counter `rcnt`, 4 bits each.
- ARMED: SINGLE(k) → `cand`=k, `hcnt`=1; if `HOLD_SAMPLES`=1 push k and go WAIT_RELEASE, else go CANDIDATE. NONE/MULTI → stay.
- CANDIDATE: SINGLE(`cand`) → `hcnt`+1; when new value equals `HOLD_SAMPLES` push `cand`, go WAIT_RELEASE. SINGLE(j≠`cand`) → `cand`=j, `hcnt`=1, stay. NONE or MULTI → ARMED, `hcnt`=0.
- WAIT_RELEASE: NONE → `rcnt`+1; when new value equals `RELEASE_SAMPLES` → ARMED, `rcnt`=0. SINGLE/MULTI → `rcnt`=0, stay.
- Entering WAIT_RELEASE clears `rcnt`; entering ARMED clears `hcnt`.
- FIFO: push on press event; pop on `press_valid && press_ready`. Push while full and no pop in the same cycle → event dropped, `overflow`=1 for that cycle, contents unchanged. Push and pop in the same cycle when full → both take effect, count unchanged, no overflow. Push and pop when count=1 → head becomes new event. Pop when empty is ignored.
- Read/write pointers wrap modulo `FIFO_DEPTH`; order strictly preserved.
- A dropped press still moves the FSM to WAIT_RELEASE (no retry).

## Timing
- Reset values: state ARMED, `hcnt`=`rcnt`=`cand`=0, FIFO empty, `press_valid`=0, `press_color`=0, `overflow`=0, `fifo_count`=0. `reset` overrides `en`, push and pop in the same cycle; reset mid-press discards all queued events and partial counts.
- Latency: push occurs at the rising edge sampling the qualifying `en`; `press_valid`/`press_color`/`fifo_count` reflect it immediately after that edge (next cycle).
- `press_color` is stable while `press_valid`=1 and not popped; after a pop edge it shows the next head (or `press_valid` drops) in the following cycle.
- `press_valid` does not depend combinationally on `press_ready`.
- `overflow` is registered, asserted the cycle after the dropping edge, for exactly one cycle.

## Test plan
- Reset then `en` pulses with `green_region`=4'b0010 ×3 → one event, `press_color`=1, `press_valid` rises the cycle after the 3rd `en`, `fifo_count`=1.
- Sequence 0100, 0100, 1100, 0100, 0100, 0100 (HOLD=3) → MULTI resets count; single event colour 2 after the 6th sample only.
- After a press, samples 0001 ×5 then 0000, 0001, 0000, 0000, then 0001 ×3 → exactly two red (0) events total; re-arm only after the two consecutive zeros.
- `press_ready`=0, five distinct presses (red, green, yellow, blue, red) with `FIFO_DEPTH`=4 → `fifo_count`=4, one `overflow` pulse on the 5th; draining yields 0,1,2,3.
- FIFO full, push and pop on same edge → no `overflow`, `fifo_count` stays 4, popped colour is oldest, new event at tail.
- Assert `reset` one cycle mid-CANDIDATE with 2 queued events → `press_valid`=0, `fifo_count`=0 next cycle; a subsequent 3-sample hold produces a fresh event.
